stereo_mpx_gen: RTL

Downstream neighbour of the L+R / L-R scaling stage. It consumes the scaled sum (L+R) and difference (L-R) samples and builds the FM stereo multiplex (MPX) baseband sample: sum/2 + (diff × 38 kHz carrier)/2 + 19 kHz pilot. Both the pilot and the carrier come from one internal phase accumulator and a quarter-wave sine table. The diff × carrier product uses a sequential shift-add multiplier. Output is one saturated MPX sample per strobe, for the FM modulator's NCO.

---
 rtl/stereo_mpx_gen.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/stereo_mpx_gen.sv
// stereo_mpx_gen: builds the FM stereo multiplex sample
//   MPX = sum/2 + (diff * c38)/2 + pilot19
// Pilot and 38 kHz carrier share one phase accumulator and a quarter-wave
// sine table. diff * carrier runs on a 16-cycle shift-add multiplier.
module stereo_mpx_gen #(
   parameter int NBITS       = 18,
   parameter int PH_BITS     = 24,
   parameter int PINC        = 1048576,
   parameter int PILOT_SHIFT = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enableclk,
   input  logic             stereo_en,
   input  logic [NBITS-1:0] SUMin,
   input  logic [NBITS-1:0] DIFin,
   output logic [NBITS-1:0] MPXout,
   output logic             MPXvalid,
   output logic             busy,
   output logic             overrun,
   output logic             pilot_sync
);

   localparam int PW = NBITS + 16;   // exact signed product width
   localparam int AW = NBITS + 2;    // accumulator width
   localparam logic [PH_BITS-1:0] PINC_V = PH_BITS'(PINC);

   typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_MUL, S_ACC, S_OUT} state_t;

   // Quarter-wave table: round(32767*sin(2*pi*k/128)), k = 0..32
   function automatic logic [15:0] qsin(input logic [5:0] k);
      case (k)
         6'd0:  qsin = 16'd0;     6'd1:  qsin = 16'd1608;  6'd2:  qsin = 16'd3212;
         6'd3:  qsin = 16'd4808;  6'd4:  qsin = 16'd6393;  6'd5:  qsin = 16'd7962;
         6'd6:  qsin = 16'd9512;  6'd7:  qsin = 16'd11039; 6'd8:  qsin = 16'd12539;
         6'd9:  qsin = 16'd14010; 6'd10: qsin = 16'd15446; 6'd11: qsin = 16'd16846;
         6'd12: qsin = 16'd18204; 6'd13: qsin = 16'd19519; 6'd14: qsin = 16'd20787;
         6'd15: qsin = 16'd22005; 6'd16: qsin = 16'd23170; 6'd17: qsin = 16'd24279;
         6'd18: qsin = 16'd25329; 6'd19: qsin = 16'd26319; 6'd20: qsin = 16'd27245;
         6'd21: qsin = 16'd28105; 6'd22: qsin = 16'd28898; 6'd23: qsin = 16'd29621;
         6'd24: qsin = 16'd30273; 6'd25: qsin = 16'd30852; 6'd26: qsin = 16'd31356;
         6'd27: qsin = 16'd31785; 6'd28: qsin = 16'd32137; 6'd29: qsin = 16'd32412;
         6'd30: qsin = 16'd32609; 6'd31: qsin = 16'd32728; 6'd32: qsin = 16'd32767;
         default: qsin = 16'd0;
      endcase
   endfunction

   // 128-point sine from the quarter table: odd quadrants mirror, upper half negates
   function automatic logic [15:0] sine128(input logic [6:0] i);
      logic [5:0]  k;
      logic [15:0] mag;
      k   = i[5] ? (6'd32 - {1'b0, i[4:0]}) : {1'b0, i[4:0]};
      mag = qsin(k);
      return i[6] ? (~mag + 16'd1) : mag;
   endfunction

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [PH_BITS-1:0]      phase_q, phase_d;
   logic [NBITS-1:0]        sum_q, sum_d;
   logic                    stereo_q, stereo_d;
   logic [15:0]             pilot_q, pilot_d;
   logic [PW-1:0]           mcand_q, mcand_d;
   logic [15:0]             mplier_q, mplier_d;
   logic [PW-1:0]           prod_q, prod_d;
   logic                    neg_q, neg_d;
   logic signed [AW-1:0]    acc_q, acc_d;
   logic [NBITS-1:0]        mpx_q, mpx_d;
   logic                    mpxvalid_q, mpxvalid_d;
   logic                    busy_q, busy_d;
   logic                    overrun_q, overrun_d;
   logic                    pilot_sync_q, pilot_sync_d;

   logic [6:0]              idx, cidx;
   logic [PH_BITS:0]        phase_sum;
   logic [15:0]             carrier, pilot_s, c_abs;
   logic [NBITS-1:0]        dif_abs;
   logic signed [PW-1:0]    prod_s;
   logic signed [AW-1:0]    t_sum, t_prod, t_pil;

   // Next-state logic: sequencing, phase/table lookup, multiplier, accumulate, saturate
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      phase_d      = phase_q;
      sum_d        = sum_q;
      stereo_d     = stereo_q;
      pilot_d      = pilot_q;
      mcand_d      = mcand_q;
      mplier_d     = mplier_q;
      prod_d       = prod_q;
      neg_d        = neg_q;
      acc_d        = acc_q;
      mpx_d        = mpx_q;
      mpxvalid_d   = 1'b0;
      busy_d       = busy_q;
      overrun_d    = overrun_q;
      pilot_sync_d = 1'b0;

      idx       = phase_q[PH_BITS-1 -: 7];
      cidx      = {idx[5:0], 1'b0};
      phase_sum = {1'b0, phase_q} + {1'b0, PINC_V};
      carrier   = sine128(cidx);
      pilot_s   = sine128(idx);
      c_abs     = carrier[15] ? (~carrier + 16'd1) : carrier;
      dif_abs   = DIFin[NBITS-1] ? (~DIFin + NBITS'(1)) : DIFin;

      // Sign is re-applied to the magnitude product, then all terms are floored
      prod_s = neg_q ? $signed(~prod_q + PW'(1)) : $signed(prod_q);
      t_sum  = $signed({{2{sum_q[NBITS-1]}}, sum_q}) >>> 1;
      t_prod = AW'(prod_s >>> 16);
      t_pil  = $signed({{(AW-16){pilot_q[15]}}, pilot_q}) >>> PILOT_SHIFT;
      if (!stereo_q) begin
         t_prod = '0;
         t_pil  = '0;
      end

      // Any strobe outside IDLE (including OUT) is dropped but remembered
      if (enableclk && state_q != S_IDLE) overrun_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (enableclk) begin
               state_d = S_CAPTURE;
               busy_d  = 1'b1;
            end
         end
         S_CAPTURE: begin
            sum_d        = SUMin;
            stereo_d     = stereo_en;
            pilot_d      = pilot_s;
            mcand_d      = {16'd0, dif_abs};
            mplier_d     = c_abs;
            neg_d        = DIFin[NBITS-1] ^ carrier[15];
            prod_d       = '0;
            cnt_d        = 4'd0;
            phase_d      = phase_sum[PH_BITS-1:0];
            pilot_sync_d = phase_sum[PH_BITS];
            state_d      = S_MUL;
         end
         S_MUL: begin
            if (mplier_q[0]) prod_d = prod_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 4'd1;
            if (cnt_q == 4'd15) state_d = S_ACC;
         end
         S_ACC: begin
            acc_d   = t_sum + t_prod + t_pil;
            state_d = S_OUT;
         end
         S_OUT: begin
            if (acc_q[AW-1:NBITS-1] == '0 || acc_q[AW-1:NBITS-1] == '1)
               mpx_d = acc_q[NBITS-1:0];
            else if (acc_q[AW-1])
               mpx_d = {1'b1, {(NBITS-1){1'b0}}};
            else
               mpx_d = {1'b0, {(NBITS-1){1'b1}}};
            mpxvalid_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         phase_q      <= '0;
         sum_q        <= '0;
         stereo_q     <= 1'b0;
         pilot_q      <= '0;
         mcand_q      <= '0;
         mplier_q     <= '0;
         prod_q       <= '0;
         neg_q        <= 1'b0;
         acc_q        <= '0;
         mpx_q        <= '0;
         mpxvalid_q   <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
         pilot_sync_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         phase_q      <= phase_d;
         sum_q        <= sum_d;
         stereo_q     <= stereo_d;
         pilot_q      <= pilot_d;
         mcand_q      <= mcand_d;
         mplier_q     <= mplier_d;
         prod_q       <= prod_d;
         neg_q        <= neg_d;
         acc_q        <= acc_d;
         mpx_q        <= mpx_d;
         mpxvalid_q   <= mpxvalid_d;
         busy_q       <= busy_d;
         overrun_q    <= overrun_d;
         pilot_sync_q <= pilot_sync_d;
      end
   end

   assign MPXout     = mpx_q;
   assign MPXvalid   = mpxvalid_q;
   assign busy       = busy_q;
   assign overrun    = overrun_q;
   assign pilot_sync = pilot_sync_q;

endmodule
